// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded clock divisor so the bit period error stays within half a clock.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready write port carrying words into the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; storage is not reset, only pointers and level.
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-buffered words serialised LSB first with optional parity,
// 1 or 2 stop bits, frames sent back-to-back while words are queued.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter  int CLK_HZ     = 12000000,
  parameter  int BAUD       = 9600,
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY     = PAR_NONE,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  uart_tx_param_if.slave   wr,
  output logic             tx,
  output logic             busy,
  output logic             idle,
  output logic [15:0]      byte_count,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_e          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 par_bit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;

  assign bit_end       = (baud_cnt == CNT_W'(DIV - 1));
  assign last_stop     = (stop_idx == 1'(STOP_BITS - 1));
  assign push          = wr.data_valid && !fifo_full;
  assign wr.data_ready = !fifo_full;
  assign busy          = (state != IDLE) || (fifo_level != '0);
  assign idle          = !busy;

  // A word leaves the FIFO when idle, or on the last stop cycle to chain frames.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP && bit_end && last_stop));

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .wdata (wr.data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= fifo_rdata;
      par_bit <= (PARITY == PAR_EVEN) ? ^fifo_rdata : ~^fifo_rdata;
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      byte_count <= '0;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) state <= START;
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_W'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? PAR : STOP;
          end
        end
        PAR: begin
          tx <= par_bit;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            stop_idx <= ~stop_idx;
            if (last_stop) begin
              stop_idx   <= 1'b0;
              byte_count <= byte_count + 16'd1;
              state      <= fifo_empty ? IDLE : START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations, a word scoreboard per instance and
// a mid-bit sampling receiver that also checks start/stop timing.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a;
  logic nrst_b;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] sb_q [5][$];

  logic [4:0]       tx_v;
  logic [4:0]       busy_v;
  logic [4:0]       idle_v;
  logic [4:0][15:0] bc_v;
  logic [4:0][2:0]  lvl_v;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();
  uart_tx_param_if #(.DATA_BITS(8)) if4 ();

  // 8N1 at 12 MHz / 9600 baud: divisor 1250
  uart_tx_param u0 (
    .clk(clk), .nrst(nrst_a), .wr(if0), .tx(tx_v[0]), .busy(busy_v[0]),
    .idle(idle_v[0]), .byte_count(bc_v[0]), .fifo_level(lvl_v[0]));

  uart_tx_param #(.PARITY(2)) u1 (
    .clk(clk), .nrst(nrst_a), .wr(if1), .tx(tx_v[1]), .busy(busy_v[1]),
    .idle(idle_v[1]), .byte_count(bc_v[1]), .fifo_level(lvl_v[1]));

  uart_tx_param #(.PARITY(1)) u2 (
    .clk(clk), .nrst(nrst_a), .wr(if2), .tx(tx_v[2]), .busy(busy_v[2]),
    .idle(idle_v[2]), .byte_count(bc_v[2]), .fifo_level(lvl_v[2]));

  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .nrst(nrst_a), .wr(if3), .tx(tx_v[3]), .busy(busy_v[3]),
    .idle(idle_v[3]), .byte_count(bc_v[3]), .fifo_level(lvl_v[3]));

  // 8N1 with a short bit period (1600 / 100 -> divisor 16) for multi-frame runs
  uart_tx_param #(.CLK_HZ(1600), .BAUD(100)) u4 (
    .clk(clk), .nrst(nrst_b), .wr(if4), .tx(tx_v[4]), .busy(busy_v[4]),
    .idle(idle_v[4]), .byte_count(bc_v[4]), .fifo_level(lvl_v[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receive one frame from instance idx; f_cyc is the cycle tx was first seen low.
  task automatic rx_frame(input int idx, input int div, input int nb, input bit has_par,
                          input int stops, input string tag, output logic [8:0] word,
                          output logic pbit, output int unsigned f_cyc, output bit ok);
    int unsigned t0;
    int unsigned lim;
    word  = '0;
    pbit  = 1'b0;
    ok    = 1'b0;
    f_cyc = 0;
    t0    = cyc;
    lim   = 20 * div + 100;
    @(negedge clk);
    while (tx_v[idx] !== 1'b0) begin
      if (cyc - t0 > lim) begin
        chk({tag, " start timeout"}, tx_v[idx], 0);
        return;
      end
      @(negedge clk);
    end
    f_cyc = cyc;
    repeat (div / 2) @(negedge clk);
    chk({tag, " start bit"}, tx_v[idx], 0);
    for (int i = 0; i < nb; i++) begin
      repeat (div) @(negedge clk);
      word[i] = tx_v[idx];
    end
    if (has_par) begin
      repeat (div) @(negedge clk);
      pbit = tx_v[idx];
    end
    for (int i = 0; i < stops; i++) begin
      repeat (div) @(negedge clk);
      chk({tag, " stop bit"}, tx_v[idx], 1);
    end
    ok = 1'b1;
  endtask

  // Single frame from an idle instance: data, parity, latency, frame length, counters.
  task automatic run_single(input int idx, input int div, input int nb, input int par,
                            input int stops, input string tag, input int unsigned push_cyc);
    logic [8:0]  w;
    logic [8:0]  exp_w;
    logic        pb;
    int unsigned f;
    bit          ok;
    int unsigned flen;
    flen = (1 + nb + ((par != 0) ? 1 : 0) + stops) * div;
    rx_frame(idx, div, nb, par != 0, stops, tag, w, pb, f, ok);
    if (!ok) return;
    chk({tag, " tx fall latency"}, f - push_cyc, 2);
    if (sb_q[idx].size() == 0) begin
      chk({tag, " unexpected frame"}, w, 9'h1FF);
      return;
    end
    exp_w = sb_q[idx].pop_front();
    chk({tag, " data"}, w, exp_w);
    if (par == 2) chk({tag, " even parity"}, pb, ^exp_w);
    if (par == 1) chk({tag, " odd parity"}, pb, ~^exp_w);
    while (cyc < f + flen - 2) @(negedge clk);
    chk({tag, " last stop tx"}, tx_v[idx], 1);
    chk({tag, " busy in last stop"}, busy_v[idx], 1);
    chk({tag, " count before end"}, bc_v[idx], 0);
    @(negedge clk);
    chk({tag, " count after end"}, bc_v[idx], 1);
    chk({tag, " idle after end"}, idle_v[idx], 1);
  endtask

  task automatic push4(input logic [7:0] w, input string tag);
    int n;
    n = 0;
    if4.data_in    = w;
    if4.data_valid = 1'b1;
    while (!if4.data_ready) begin
      n++;
      if (n > 2000) begin
        chk({tag, " ready timeout"}, if4.data_ready, 1);
        if4.data_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb_q[4].push_back({1'b0, w});
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int unsigned pc;
    logic [8:0]  w1;
    logic        pb1;
    int unsigned f1;
    bit          ok1;

    nrst_a = 1'b0;
    nrst_b = 1'b0;
    if0.data_in = '0; if0.data_valid = 1'b0;
    if1.data_in = '0; if1.data_valid = 1'b0;
    if2.data_in = '0; if2.data_valid = 1'b0;
    if3.data_in = '0; if3.data_valid = 1'b0;
    if4.data_in = '0; if4.data_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst tx", tx_v[0], 1);
    chk("rst busy", busy_v[0], 0);
    chk("rst idle", idle_v[0], 1);
    chk("rst ready", if0.data_ready, 1);
    chk("rst count", bc_v[0], 0);
    chk("rst level", lvl_v[0], 0);
    chk("rst tx u4", tx_v[4], 1);
    chk("rst idle u4", idle_v[4], 1);

    nrst_a = 1'b1;
    nrst_b = 1'b1;
    repeat (2) @(negedge clk);

    chk("ready u1", if1.data_ready, 1);
    chk("ready u2", if2.data_ready, 1);
    chk("ready u3", if3.data_ready, 1);

    if0.data_in = 8'h53; if0.data_valid = 1'b1; sb_q[0].push_back(9'h053);
    if1.data_in = 8'h53; if1.data_valid = 1'b1; sb_q[1].push_back(9'h053);
    if2.data_in = 8'h53; if2.data_valid = 1'b1; sb_q[2].push_back(9'h053);
    if3.data_in = 7'h41; if3.data_valid = 1'b1; sb_q[3].push_back(9'h041);
    @(negedge clk);
    pc = cyc;
    if0.data_valid = 1'b0; if1.data_valid = 1'b0;
    if2.data_valid = 1'b0; if3.data_valid = 1'b0;
    // data_in wiggles with no handshake must not reach the line
    if0.data_in = 8'hFF;
    if3.data_in = 7'h3E;

    fork
      run_single(0, 1250, 8, 0, 1, "8N1", pc);
      run_single(1, 1250, 8, 2, 1, "8E1", pc);
      run_single(2, 1250, 8, 1, 1, "8O1", pc);
      run_single(3, 1250, 7, 1, 2, "7O2", pc);
    join

    fork
      begin : drv
        for (int i = 0; i < 6; i++) begin
          push4(8'h10 + 8'(i), "burst push");
          if (i == 1) chk("level on push+pop", lvl_v[4], 1);
          if (i == 4) begin
            chk("level full", lvl_v[4], 4);
            chk("ready when full", if4.data_ready, 0);
          end
        end
        chk("level after last push", lvl_v[4], 4);
        if4.data_in = 8'hAA;
        repeat (5) begin
          @(negedge clk);
          chk("full push level", lvl_v[4], 4);
          chk("full push ready", if4.data_ready, 0);
        end
        if4.data_valid = 1'b0;
      end
      begin : mon
        int unsigned fprev;
        logic [8:0]  w;
        logic        pb;
        int unsigned f;
        bit          ok;
        fprev = 0;
        for (int i = 0; i < 6; i++) begin
          rx_frame(4, 16, 8, 1'b0, 1, "burst", w, pb, f, ok);
          if (!ok) break;
          if (sb_q[4].size() == 0) chk("burst extra frame", w, 9'h1FF);
          else chk("burst data", w, sb_q[4].pop_front());
          if (i > 0) chk("burst frame spacing", f - fprev, 160);
          fprev = f;
        end
      end
    join

    repeat (200) @(negedge clk);
    chk("burst count", bc_v[4], 6);
    chk("burst idle", idle_v[4], 1);
    chk("burst level", lvl_v[4], 0);
    chk("burst leftover words", sb_q[4].size(), 0);

    push4(8'h3C, "rst-test push");
    push4(8'h00, "rst-test push");
    if4.data_valid = 1'b0;
    rx_frame(4, 16, 8, 1'b0, 1, "rst-test f1", w1, pb1, f1, ok1);
    if (ok1) begin
      chk("rst-test f1 data", w1, sb_q[4].pop_front());
      while (cyc < f1 + 160 + 16 * 4 + 8) @(negedge clk);
      chk("mid-frame tx", tx_v[4], 0);
      chk("mid-frame count", bc_v[4], 7);
      nrst_b = 1'b0;
      #1;
      chk("abort tx", tx_v[4], 1);
      chk("abort level", lvl_v[4], 0);
      chk("abort count", bc_v[4], 0);
      chk("abort idle", idle_v[4], 1);
      chk("abort ready", if4.data_ready, 1);
    end
    sb_q[4].delete();
    repeat (2) @(negedge clk);
    nrst_b = 1'b1;
    @(negedge clk);
    push4(8'hFF, "post-rst push");
    pc = cyc;
    if4.data_valid = 1'b0;
    run_single(4, 16, 8, 0, 1, "post-rst", pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
